hwpe_cfg_bridge: RTL
====================

# hwpe_cfg_bridge

Registered bridge between the cluster peripheral interconnect and the HWPE subsystem configuration port. It accepts one configuration access at a time from the cluster side, replays it toward the HWPE, and returns the response with the original ID. A response-phase watchdog converts a hung HWPE register access into an error response, so a misbehaving accelerator cannot stall a core's peripheral access indefinitely. It sits directly upstream of the HWPE subsystem's configuration slave.

## Interface

Parameters:
- ID_WIDTH, 8, transaction ID width (matches the peripheral bus ID).
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 256, response-phase watchdog limit in cycles (≥2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- slv_req  in  1  upstream request.
- slv_add  in  ADDR_WIDTH  upstream address.
- slv_wen  in  1  1 = read, 0 = write.
- slv_be  in  4  byte enables.
- slv_wdata  in  32  write data.
- slv_id  in  ID_WIDTH  request ID.
- slv_gnt  out  1  upstream grant.
- slv_r_valid  out  1  upstream response valid, one cycle.
- slv_r_rdata  out  32  response data.
- slv_r_id  out  ID_WIDTH  response ID.
- slv_r_opc  out  1  1 = error (timeout).
- mst_req  out  1  downstream request toward HWPE cfg.
- mst_add, mst_wen, mst_be, mst_wdata, mst_id  out  as slv_*  registered request fields.
- mst_gnt  in  1  downstream grant.
- mst_r_valid  in  1  downstream response valid.
- mst_r_rdata  in  32  downstream response data.
- busy_o  out  1  state ≠ IDLE.

## Operation

- FSM states: IDLE, REQ, RESP, RSP, ABORT.
- IDLE: slv_gnt = 1 (combinational, IDLE only). On slv_req, capture add/wen/be/wdata/id into request registers → REQ.
- REQ: mst_req = 1 with registered fields; held stable until mst_gnt. On mst_gnt → RESP, clear watchdog counter.
- RESP: counter increments each cycle. On mst_r_valid: capture mst_r_rdata, opc = 0 → RSP. If mst_r_valid is absent when counter == TIMEOUT-1: rdata = 32'hDEAD_BEEF, opc = 1, set err flag → RSP. mst_r_valid wins if it coincides with the timeout.
- RSP: slv_r_valid = 1 for exactly one cycle with the captured rdata, opc and the stored ID. Go to ABORT if err flag is set, else IDLE.
- ABORT: slv_gnt = 0. Exit to IDLE when a late mst_r_valid arrives (discarded, never forwarded) or when the counter (restarted on entry) reaches TIMEOUT-1.
- No request is ever withdrawn from the master side once mst_req is asserted.
- Writes and reads follow the same path; slv_r_rdata for writes is whatever the HWPE returns.

## Timing

- Reset values:
  - state = IDLE.
  - slv_gnt = 1 (from IDLE).
  - slv_r_valid = 0, slv_r_rdata = 0, slv_r_id = 0, slv_r_opc = 0.
  - mst_req = 0 and all mst_* fields = 0.
  - busy_o = 0.
  - Counter and err flag = 0.
- Minimum latency: request accepted at cycle 0; mst_req in cycle 1; with mst_gnt and mst_r_valid both at their earliest (cycles 1 and 2), slv_r_valid appears in cycle 3. The next grant is in cycle 4.
- Throughput: at most one transaction per 4 cycles.
- Timeout response appears TIMEOUT+1 cycles after the mst_gnt cycle.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. No response is emitted and request registers are cleared.
- The counter width is clog2(TIMEOUT) and it saturates; it never wraps.

## Structure

- Shared package hwpe_cfg_pkg holds:
  - the FSM state enum hwpe_cfg_state_e;
  - the constant HWPE_CFG_ERR_DATA = 32'hDEAD_BEEF;
  - the request struct hwpe_cfg_req_t (add, wen, be, wdata, id), used for the capture register.
- One sub-module is natural: hwpe_cfg_watchdog, a clearable saturating counter with clear/enable inputs and an expired output, used in both RESP and ABORT.

## Test plan

- Read, zero-wait HWPE: read with add=0x10, id=0x5A; mst_gnt in cycle 1; mst_r_valid with rdata=0x1234_5678 in cycle 2 → slv_r_valid in cycle 3 with rdata 0x1234_5678, id 0x5A, opc 0. slv_gnt high again in cycle 4.
- Write with grant backpressure: mst_gnt held low 5 cycles → mst_req and all fields are stable for 6 cycles; slv_gnt stays 0 throughout; the response returns the correct ID.
- Timeout (TIMEOUT=8): no mst_r_valid after grant → slv_r_valid 9 cycles after the grant cycle with rdata 0xDEAD_BEEF and opc 1. A late mst_r_valid 3 cycles later is not forwarded, and IDLE follows.
- Coincident events: mst_r_valid in the exact timeout cycle → data response with opc 0 and no ABORT.
- Reset mid-RESP: rst pulsed → all outputs at reset values, busy_o=0, and the next request completes normally.
- Back-to-back requests: slv_req held high with 3 different IDs → exactly 3 grants, responses in order with matching IDs, and one grant per 4 cycles.

Source files
------------

// File: rtl/hwpe_cfg_pkg.sv
// Shared types and constants for the HWPE configuration bridge.
// The request struct is sized for the default 32-bit address / 8-bit ID bus.
package hwpe_cfg_pkg;

  localparam int unsigned HWPE_CFG_ADDR_W = 32;
  localparam int unsigned HWPE_CFG_ID_W   = 8;

  localparam logic [31:0] HWPE_CFG_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    RSP,
    ABORT
  } hwpe_cfg_state_e;

  typedef struct packed {
    logic [HWPE_CFG_ADDR_W-1:0] add;
    logic                       wen;
    logic [3:0]                 be;
    logic [31:0]                wdata;
    logic [HWPE_CFG_ID_W-1:0]   id;
  } hwpe_cfg_req_t;

endpackage

// File: rtl/hwpe_cfg_bridge_if.sv
// Cluster-side and HWPE-side configuration bus of the bridge.
// 'slave' is the bridge's view; 'master' is the surrounding system's view.
interface hwpe_cfg_bridge_if #(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  slv_req;
  logic [ADDR_WIDTH-1:0] slv_add;
  logic                  slv_wen;
  logic [3:0]            slv_be;
  logic [31:0]           slv_wdata;
  logic [ID_WIDTH-1:0]   slv_id;
  logic                  slv_gnt;
  logic                  slv_r_valid;
  logic [31:0]           slv_r_rdata;
  logic [ID_WIDTH-1:0]   slv_r_id;
  logic                  slv_r_opc;

  logic                  mst_req;
  logic [ADDR_WIDTH-1:0] mst_add;
  logic                  mst_wen;
  logic [3:0]            mst_be;
  logic [31:0]           mst_wdata;
  logic [ID_WIDTH-1:0]   mst_id;
  logic                  mst_gnt;
  logic                  mst_r_valid;
  logic [31:0]           mst_r_rdata;

  modport slave (
    input  slv_req, slv_add, slv_wen, slv_be, slv_wdata, slv_id,
    output slv_gnt, slv_r_valid, slv_r_rdata, slv_r_id, slv_r_opc,
    output mst_req, mst_add, mst_wen, mst_be, mst_wdata, mst_id,
    input  mst_gnt, mst_r_valid, mst_r_rdata
  );

  modport master (
    output slv_req, slv_add, slv_wen, slv_be, slv_wdata, slv_id,
    input  slv_gnt, slv_r_valid, slv_r_rdata, slv_r_id, slv_r_opc,
    input  mst_req, mst_add, mst_wen, mst_be, mst_wdata, mst_id,
    output mst_gnt, mst_r_valid, mst_r_rdata
  );

endinterface

// File: rtl/hwpe_cfg_watchdog.sv
// Clearable saturating cycle counter; 'expired' is high while the count sits
// at TIMEOUT-1, and the counter holds there instead of wrapping.
module hwpe_cfg_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/hwpe_cfg_bridge.sv
// One-outstanding configuration bridge toward the HWPE cfg port, with a
// response watchdog that turns a hung access into an error response.
module hwpe_cfg_bridge
  import hwpe_cfg_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = HWPE_CFG_ID_W,
  parameter int unsigned ADDR_WIDTH = HWPE_CFG_ADDR_W,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  hwpe_cfg_bridge_if.slave       bus,
  output logic                   busy_o
);

  hwpe_cfg_state_e state_q, state_d;
  hwpe_cfg_req_t   req_q;
  logic [31:0]     rdata_q;
  logic            opc_q;
  logic            err_q;

  logic capture, rsp_load, rsp_err;
  logic wd_clr, wd_en, wd_expired;

  hwpe_cfg_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    rsp_load        = 1'b0;
    rsp_err         = 1'b0;
    wd_clr          = 1'b0;
    wd_en           = 1'b0;
    bus.slv_gnt     = 1'b0;
    bus.slv_r_valid = 1'b0;
    bus.mst_req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.slv_gnt = 1'b1;
        wd_clr      = 1'b1;
        if (bus.slv_req) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.mst_req = 1'b1;
        wd_clr      = 1'b1;
        if (bus.mst_gnt) state_d = RESP;
      end
      RESP: begin
        wd_en = 1'b1;
        // A real response beats the watchdog when both land in the same cycle.
        if (bus.mst_r_valid) begin
          rsp_load = 1'b1;
          state_d  = RSP;
        end else if (wd_expired) begin
          rsp_load = 1'b1;
          rsp_err  = 1'b1;
          state_d  = RSP;
        end
      end
      RSP: begin
        bus.slv_r_valid = 1'b1;
        wd_clr          = 1'b1;
        state_d         = err_q ? ABORT : IDLE;
      end
      ABORT: begin
        // Swallow the straggling response (or give up after another window).
        wd_en = 1'b1;
        if (bus.mst_r_valid || wd_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured request and response are reset too, because they drive
  // the bus outputs directly and must read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      opc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        req_q <= '{
          add:   HWPE_CFG_ADDR_W'(bus.slv_add),
          wen:   bus.slv_wen,
          be:    bus.slv_be,
          wdata: bus.slv_wdata,
          id:    HWPE_CFG_ID_W'(bus.slv_id)
        };
      end
      if (rsp_load) begin
        rdata_q <= rsp_err ? HWPE_CFG_ERR_DATA : bus.mst_r_rdata;
        opc_q   <= rsp_err;
        err_q   <= rsp_err;
      end else if (state_q == RSP) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.mst_add     = ADDR_WIDTH'(req_q.add);
  assign bus.mst_wen     = req_q.wen;
  assign bus.mst_be      = req_q.be;
  assign bus.mst_wdata   = req_q.wdata;
  assign bus.mst_id      = ID_WIDTH'(req_q.id);
  assign bus.slv_r_rdata = rdata_q;
  assign bus.slv_r_id    = ID_WIDTH'(req_q.id);
  assign bus.slv_r_opc   = opc_q;
  assign busy_o          = (state_q != IDLE);

endmodule
